// File: rtl/diff_rr_scheduler.sv
// Round-robin scheduler sharing one first-difference datapath (diff = x - prev) among NCH channels.
// Optional DIFF_SAT_EN: saturate out_diff to the signed W-bit range and flag clamping on out_sat.
module diff_rr_scheduler #(
   parameter int unsigned NCH = 4,
   parameter int unsigned W   = 32,
   parameter int unsigned CHW = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [NCH-1:0]   req_valid,
   input  logic [NCH*W-1:0] req_x,
   output logic [NCH-1:0]   req_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHW-1:0]   out_ch,
   output logic [W-1:0]     out_x,
   output logic [W-1:0]     out_prev,
   output logic [W-1:0]     out_diff,
   output logic             out_first,
   output logic             out_sat
);

   logic [CHW-1:0] ptr_q;
   logic [W-1:0]   prev_q [NCH];
   logic [NCH-1:0] first_q;

   logic           found;
   logic [CHW-1:0] win;
   logic           stall;
   logic           accept;
   logic [W-1:0]   x_sel;
   logic [W-1:0]   prev_sel;
   logic           first_sel;
   logic [W-1:0]   diff_n;
   logic           sat_n;

   // Rotating priority search starting at ptr_q, wrapping modulo NCH
   always_comb begin
      logic [CHW:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = {1'b0, ptr_q} + (CHW+1)'(i);
         if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
         if (!found && req_valid[idx[CHW-1:0]]) begin
            found = 1'b1;
            win   = idx[CHW-1:0];
         end
      end
   end

   assign stall     = out_valid & ~out_ready;
   assign accept    = found & ~clr & ~stall & ~rst;
   assign req_ready = accept ? (NCH'(1) << win) : '0;

   assign x_sel     = req_x[win*W +: W];
   assign prev_sel  = prev_q[win];
   assign first_sel = first_q[win];

`ifdef DIFF_SAT_EN
   logic [W:0] d_ext;

   // Full-precision difference; clamp when the top two bits disagree
   always_comb begin
      d_ext  = {x_sel[W-1], x_sel} - {prev_sel[W-1], prev_sel};
      sat_n  = 1'b0;
      diff_n = d_ext[W-1:0];
      if (d_ext[W] != d_ext[W-1]) begin
         sat_n  = 1'b1;
         diff_n = d_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   // Two's-complement wrap equals the low W bits of the W+1-bit difference
   always_comb begin
      diff_n = x_sel - prev_sel;
      sat_n  = 1'b0;
   end
`endif

   // Per-channel history and RR pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         first_q <= '1;
         for (int i = 0; i < NCH; i++) prev_q[i] <= '0;
      end else if (clr) begin
         ptr_q   <= '0;
         first_q <= '1;
         for (int i = 0; i < NCH; i++) prev_q[i] <= '0;
      end else if (accept) begin
         ptr_q         <= (win == CHW'(NCH-1)) ? '0 : win + CHW'(1);
         prev_q[win]   <= x_sel;
         first_q[win]  <= 1'b0;
      end
   end

   // Result register: load on accept, hold while stalled, drain on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_x     <= '0;
         out_prev  <= '0;
         out_diff  <= '0;
         out_first <= 1'b0;
         out_sat   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_ch    <= win;
         out_x     <= x_sel;
         out_prev  <= prev_sel;
         out_diff  <= diff_n;
         out_first <= first_sel;
         out_sat   <= sat_n;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
